// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings
// and the reserved-mode predicate.
package imm_ext_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SEXT      = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ZEXT      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_UPPER     = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BRANCH    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_HALF_SEXT = 3'd4;

  // Every encoding above HALF_SEXT is reserved and flagged as an error.
  function automatic logic isReserved(input logic [MODE_W-1:0] mode);
    return (mode > MODE_HALF_SEXT);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: raw field plus mode in,
// extended value and reserved-mode flag out.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]  data,
  output logic              err
);

  localparam int HALF_W = IN_W / 2;

  if (OUT_W < IN_W + 2) begin : g_badWidth
    $error("imm_ext_core: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] w_sext;

  always_comb begin
    w_sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    data   = '0;
    err    = isReserved(in_mode);
    case (in_mode)
      MODE_SEXT:      data = w_sext;
      MODE_ZEXT:      data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      MODE_UPPER:     data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      // The branch offset is word-scaled; the top two sign bits fall off.
      MODE_BRANCH:    data = {w_sext[OUT_W-3:0], 2'b00};
      MODE_HALF_SEXT: data = {{(OUT_W-HALF_W){in_imm[HALF_W-1]}}, in_imm[HALF_W-1:0]};
      default:        data = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender behind a valid/ready stage with one output register
// and one skid entry, plus a saturating reserved-mode error counter.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  logic [OUT_W-1:0] w_extData;
  logic             w_extErr;
  logic             w_accept;
  logic             w_outXfer;
  logic             w_skidNext;

  logic             r_outValid;
  logic [OUT_W-1:0] r_outData;
  logic             r_outErr;
  logic             r_skidValid;
  logic [OUT_W-1:0] r_skidData;
  logic             r_skidErr;
  logic             r_inReady;
  logic [7:0]       r_errCnt;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .data    (w_extData),
    .err     (w_extErr)
  );

  assign w_accept  = in_valid && r_inReady;
  assign w_outXfer = r_outValid && out_ready;
  // The skid only fills when the output register is occupied and stalled.
  assign w_skidNext = r_skidValid ? !w_outXfer
                                  : (w_accept && r_outValid && !w_outXfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_outErr    <= 1'b0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
      r_skidErr   <= 1'b0;
      r_inReady   <= 1'b0;
    end else begin
      r_inReady   <= !w_skidNext;
      r_skidValid <= w_skidNext;
      if (r_skidValid) begin
        if (w_outXfer) begin
          r_outData <= r_skidData;
          r_outErr  <= r_skidErr;
        end
      end else if (w_accept) begin
        if (!r_outValid || w_outXfer) begin
          r_outValid <= 1'b1;
          r_outData  <= w_extData;
          r_outErr   <= w_extErr;
        end else begin
          r_skidData <= w_extData;
          r_skidErr  <= w_extErr;
        end
      end else if (w_outXfer) begin
        r_outValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errCnt <= 8'd0;
    end else if (w_outXfer && r_outErr && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_err   = r_outErr;
  assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: arithmetic reference model with a
// queue scoreboard, plus directed vectors with literal expectations.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  logic [32:0] modelQ[$];
  int          expCnt = 0;
  bit          armed  = 0;

  imm_ext_pipe #(
    .IN_W  (16),
    .OUT_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {err, data} computed with plain signed arithmetic.
  function automatic logic [32:0] refExt(input logic [15:0] imm, input logic [2:0] mode);
    longint sv;
    longint hv;
    longint res;
    logic [63:0] bits;
    sv = imm[15] ? longint'(imm) - 65536 : longint'(imm);
    hv = longint'(imm) % 256;
    if (hv >= 128) hv = hv - 256;
    res = 0;
    case (mode)
      3'd0: res = sv;
      3'd1: res = longint'(imm);
      3'd2: res = longint'(imm) * 65536;
      3'd3: res = sv * 4;
      3'd4: res = hv;
      default: return {1'b1, 32'h0};
    endcase
    bits = 64'(res);
    return {1'b0, bits[31:0]};
  endfunction

  // Scoreboard: check every falling edge, then advance the model by what
  // the next rising edge will do.
  always @(negedge clk) begin
    logic [32:0] front;
    bit expReady;
    bit expValid;
    if (!rst_n) begin
      modelQ.delete();
      expCnt = 0;
      armed  = 0;
      checkOutput("rst out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("rst out_data", out_data, 32'd0);
    end else begin
      expReady = armed && (modelQ.size() < 2);
      expValid = (modelQ.size() > 0);
      checkOutput("model out_valid", 32'(out_valid), 32'(expValid));
      checkOutput("model in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("model err_cnt", 32'(err_cnt), 32'(expCnt));
      if (expValid) begin
        front = modelQ[0];
        checkOutput("model out_data", out_data, front[31:0]);
        checkOutput("model out_err", 32'(out_err), 32'(front[32]));
      end
      if (expValid && out_ready) begin
        front = modelQ.pop_front();
        if (front[32] && expCnt < 255) expCnt++;
      end
      if (in_valid && expReady) modelQ.push_back(refExt(in_imm, in_mode));
      armed = 1;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one item and hold it until accepted; returns 1 time unit after
  // the accepting edge with garbage on the idle inputs.
  task automatic applyStimulus(input logic [15:0] imm, input logic [2:0] mode);
    int guard;
    guard    = 0;
    in_imm   = imm;
    in_mode  = mode;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("accept timeout", 32'd0, 32'd1);
    stepCycle();
    in_valid = 1'b0;
    in_imm   = 16'($urandom);
    in_mode  = 3'($urandom_range(0, 7));
  endtask

  task automatic checkSingle(input string name, input logic [15:0] imm,
                             input logic [2:0] mode, input logic [31:0] exp);
    applyStimulus(imm, mode);
    @(negedge clk);
    checkOutput({name, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, " data"}, out_data, exp);
    checkOutput({name, " err"}, 32'(out_err), 32'd0);
    stepCycle();
  endtask

  initial begin
    int sent;
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = 16'h0;
    in_mode   = 3'd0;
    out_ready = 1'b0;
    repeat (2) stepCycle();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready low", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("post-reset in_ready high", 32'(in_ready), 32'd1);
    stepCycle();

    $display("[TB] extension modes");
    out_ready = 1'b1;
    checkSingle("sext", 16'hF234, 3'd0, 32'hFFFFF234);
    checkSingle("zext", 16'hF234, 3'd1, 32'h0000F234);
    checkSingle("upper", 16'h1234, 3'd2, 32'h12340000);
    checkSingle("branch", 16'hFFFF, 3'd3, 32'hFFFFFFFC);
    checkSingle("half_sext", 16'h1280, 3'd4, 32'hFFFFFF80);
    checkSingle("half_sext pos", 16'hFF7F, 3'd4, 32'h0000007F);
    checkSingle("branch pos", 16'h4001, 3'd3, 32'h00010004);

    $display("[TB] skid backpressure");
    out_ready = 1'b0;
    repeat (2) stepCycle();
    applyStimulus(16'h0001, 3'd0);
    applyStimulus(16'h0002, 3'd1);
    @(negedge clk);
    checkOutput("skid in_ready low", 32'(in_ready), 32'd0);
    checkOutput("skid hold A", out_data, 32'h00000001);
    stepCycle();
    @(negedge clk);
    checkOutput("skid still held A", out_data, 32'h00000001);
    stepCycle();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain A", out_data, 32'h00000001);
    stepCycle();
    @(negedge clk);
    checkOutput("drain B", out_data, 32'h00000002);
    checkOutput("drain in_ready", 32'(in_ready), 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("drain empty", 32'(out_valid), 32'd0);
    stepCycle();

    $display("[TB] reserved modes and error counter");
    applyStimulus(16'hABCD, 3'd5);
    @(negedge clk);
    checkOutput("reserved data", out_data, 32'h0);
    checkOutput("reserved err", 32'(out_err), 32'd1);
    @(negedge clk);
    checkOutput("err_cnt one", 32'(err_cnt), 32'd1);
    stepCycle();
    for (int i = 0; i < 300; i++) applyStimulus(16'(i), 3'(5 + (i % 3)));
    repeat (2) stepCycle();
    @(negedge clk);
    checkOutput("err_cnt saturate", 32'(err_cnt), 32'd255);
    stepCycle();

    $display("[TB] reset while skid full");
    out_ready = 1'b0;
    applyStimulus(16'h0011, 3'd1);
    applyStimulus(16'h0022, 3'd1);
    @(negedge clk);
    checkOutput("pre-reset in_ready", 32'(in_ready), 32'd0);
    stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async out_valid", 32'(out_valid), 32'd0);
    checkOutput("async err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("async in_ready", 32'(in_ready), 32'd0);
    repeat (2) stepCycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no stale item", 32'(out_valid), 32'd0);
    end
    stepCycle();

    $display("[TB] random stream");
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      stepCycle();
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("random sent", 32'(sent), 32'd1000);
    out_ready = 1'b1;
    repeat (4) stepCycle();
    @(negedge clk);
    checkOutput("random drained valid", 32'(out_valid), 32'd0);
    checkOutput("random model empty", 32'(modelQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
